// File: rtl/set_assoc_cache.sv
// N-way set-associative write-through, no-write-allocate data cache.
// True-LRU replacement, single-cycle flush, hit/miss event counters.
module set_assoc_cache #(
  parameter int WIDTH    = 32,
  parameter int SET_BITS = 4,
  parameter int WAYS     = 4,
  parameter int TAG_BITS = WIDTH - SET_BITS - 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cpu_req_i,
  input  logic             cpu_we_i,
  input  logic [WIDTH-1:0] cpu_addr_i,
  input  logic [WIDTH-1:0] cpu_wdata_i,
  output logic             cpu_ready_o,
  output logic             cpu_resp_valid_o,
  output logic [WIDTH-1:0] cpu_rdata_o,
  input  logic             flush_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0] mem_wdata_o,
  input  logic [WIDTH-1:0] mem_rdata_i,
  input  logic             mem_ack_i,
  output logic [31:0]      hit_count_o,
  output logic [31:0]      miss_count_o
);

  localparam int SETS = 1 << SET_BITS;
  localparam int AW   = $clog2(WAYS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_MEM_RD,
    S_MEM_WR
  } state_t;

  state_t state_q;

  logic             we_q;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] rdata_q;
  logic             resp_q;
  logic [31:0]      hit_cnt_q;
  logic [31:0]      miss_cnt_q;

  logic [WAYS-1:0]     valid_q [SETS];
  logic [AW-1:0]       age_q   [SETS][WAYS];
  logic [TAG_BITS-1:0] tag_q   [SETS][WAYS];
  logic [WIDTH-1:0]    data_q  [SETS][WAYS];

  logic [SET_BITS-1:0] set_idx;
  logic [TAG_BITS-1:0] tag_in;
  logic                hit;
  logic [AW-1:0]       hit_way;
  logic                inv_found;
  logic [AW-1:0]       inv_way;
  logic [AW-1:0]       lru_way;
  logic [AW-1:0]       victim;
  logic [AW-1:0]       touch_way;
  logic [AW-1:0]       age_nxt [WAYS];
  logic                unused_lsb;

  assign set_idx    = addr_q[SET_BITS+1:2];
  assign tag_in     = addr_q[WIDTH-1:SET_BITS+2];
  assign unused_lsb = ^addr_q[1:0];

  // Tag match across all valid ways of the addressed set
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[set_idx][w] && (tag_q[set_idx][w] == tag_in)) begin
        hit     = 1'b1;
        hit_way = AW'(w);
      end
    end
  end

  // Victim: lowest invalid way, otherwise the oldest way
  always_comb begin
    inv_found = 1'b0;
    inv_way   = '0;
    lru_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!inv_found && !valid_q[set_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = AW'(w);
      end
      if (age_q[set_idx][w] == AW'(WAYS - 1)) begin
        lru_way = AW'(w);
      end
    end
    victim = inv_found ? inv_way : lru_way;
  end

  assign touch_way = (state_q == S_LOOKUP) ? hit_way : victim;

  // Ages after touching touch_way: younger ways age by one
  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      age_nxt[w] = age_q[set_idx][w];
      if (AW'(w) == touch_way) begin
        age_nxt[w] = '0;
      end else if (age_q[set_idx][w] < age_q[set_idx][touch_way]) begin
        age_nxt[w] = age_q[set_idx][w] + 1'b1;
      end
    end
  end

  // Control FSM with valid/LRU state, counters and CPU response
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      resp_q     <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          age_q[s][w] <= AW'(w);
        end
      end
    end else begin
      resp_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (cpu_req_i) begin
            we_q    <= cpu_we_i;
            addr_q  <= cpu_addr_i;
            wdata_q <= cpu_wdata_i;
            state_q <= S_LOOKUP;
          end else if (flush_i) begin
            for (int s = 0; s < SETS; s++) begin
              valid_q[s] <= '0;
            end
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            hit_cnt_q <= hit_cnt_q + 32'd1;
            for (int w = 0; w < WAYS; w++) begin
              age_q[set_idx][w] <= age_nxt[w];
            end
          end else begin
            miss_cnt_q <= miss_cnt_q + 32'd1;
          end
          if (we_q) begin
            state_q <= S_MEM_WR;
          end else if (hit) begin
            rdata_q <= data_q[set_idx][hit_way];
            resp_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            state_q <= S_MEM_RD;
          end
        end
        S_MEM_RD: begin
          if (mem_ack_i) begin
            valid_q[set_idx][victim] <= 1'b1;
            for (int w = 0; w < WAYS; w++) begin
              age_q[set_idx][w] <= age_nxt[w];
            end
            rdata_q <= mem_rdata_i;
            resp_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        S_MEM_WR: begin
          if (mem_ack_i) begin
            resp_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Tag/data arrays: write-hit update and read-miss fill
  always_ff @(posedge clk_i) begin
    if (state_q == S_LOOKUP && we_q && hit) begin
      data_q[set_idx][hit_way] <= wdata_q;
    end else if (state_q == S_MEM_RD && mem_ack_i) begin
      data_q[set_idx][victim] <= mem_rdata_i;
      tag_q[set_idx][victim]  <= tag_in;
    end
  end

  assign cpu_ready_o      = (state_q == S_IDLE);
  assign cpu_resp_valid_o = resp_q;
  assign cpu_rdata_o      = rdata_q;
  assign mem_req_o        = (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign mem_we_o         = (state_q == S_MEM_WR);
  assign mem_addr_o       = {addr_q[WIDTH-1:2], 2'b00};
  assign mem_wdata_o      = wdata_q;
  assign hit_count_o      = hit_cnt_q;
  assign miss_count_o     = miss_cnt_q;

endmodule

// File: tb/tb_set_assoc_cache.sv
// Bench for set_assoc_cache: directed plan plus random traffic
// checked against a recency-list cache model and a word memory.
module tb_set_assoc_cache;

  localparam int SETS = 16;
  localparam int WAYS = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, flush;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_ready, cpu_resp_valid;
  logic [31:0] cpu_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] hit_count, miss_count;

  always #5 clk = ~clk;

  set_assoc_cache dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .cpu_req_i        (cpu_req),
    .cpu_we_i         (cpu_we),
    .cpu_addr_i       (cpu_addr),
    .cpu_wdata_i      (cpu_wdata),
    .cpu_ready_o      (cpu_ready),
    .cpu_resp_valid_o (cpu_resp_valid),
    .cpu_rdata_o      (cpu_rdata),
    .flush_i          (flush),
    .mem_req_o        (mem_req),
    .mem_we_o         (mem_we),
    .mem_addr_o       (mem_addr),
    .mem_wdata_o      (mem_wdata),
    .mem_rdata_i      (mem_rdata),
    .mem_ack_i        (mem_ack),
    .hit_count_o      (hit_count),
    .miss_count_o     (miss_count)
  );

  int checks = 0;
  int errors = 0;

  // Model: per set, resident word addresses in most-recent-first order
  int          m_cnt [SETS];
  logic [31:0] m_wa  [SETS][WAYS];
  logic [31:0] m_d   [SETS][WAYS];
  int          m_hits, m_miss;
  logic [31:0] last_rd;
  logic [31:0] mem [logic [31:0]];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] memrd(input logic [31:0] wa);
    if (mem.exists(wa)) return mem[wa];
    return (wa * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  function automatic int m_find(input int s, input logic [31:0] wa);
    for (int i = 0; i < m_cnt[s]; i++)
      if (m_wa[s][i] == wa) return i;
    return -1;
  endfunction

  task automatic m_touch(input int s, input int i);
    logic [31:0] a, d;
    a = m_wa[s][i];
    d = m_d[s][i];
    for (int j = i; j > 0; j--) begin
      m_wa[s][j] = m_wa[s][j-1];
      m_d[s][j]  = m_d[s][j-1];
    end
    m_wa[s][0] = a;
    m_d[s][0]  = d;
  endtask

  task automatic m_fill(input int s, input logic [31:0] wa,
                        input logic [31:0] d);
    if (m_cnt[s] < WAYS) m_cnt[s]++;
    for (int j = m_cnt[s] - 1; j > 0; j--) begin
      m_wa[s][j] = m_wa[s][j-1];
      m_d[s][j]  = m_d[s][j-1];
    end
    m_wa[s][0] = wa;
    m_d[s][0]  = d;
  endtask

  task automatic m_clear();
    for (int s = 0; s < SETS; s++) m_cnt[s] = 0;
  endtask

  // One CPU request; memory answers after lat request cycles
  task automatic req(input bit we, input logic [31:0] a,
                     input logic [31:0] wd, input int lat);
    logic [31:0] wa, exp_rd, ma, mw, md;
    int s, i, n, mc, exp_lat;
    bit hit, exp_mem, done;
    wa      = a & ~32'h3;
    s       = int'((a >> 2) & 32'hF);
    i       = m_find(s, wa);
    hit     = (i >= 0);
    exp_mem = !(hit && !we);
    exp_lat = exp_mem ? 2 + lat : 2;
    if (we) exp_rd = last_rd;
    else if (hit) exp_rd = m_d[s][i];
    else exp_rd = memrd(wa);

    @(negedge clk);
    chk("ready_before_req", cpu_ready, 1);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = wd;
    @(negedge clk);
    cpu_req   = 1'b0;
    cpu_we    = 1'($urandom);
    cpu_addr  = $urandom;
    cpu_wdata = $urandom;
    n = 1; mc = 0; done = 0;
    ma = '0; mw = '0; md = '0;
    while (!done && n < 64) begin
      if (cpu_resp_valid) begin
        done = 1;
      end else begin
        if (mem_req) begin
          mc++;
          if (mc == 1) begin
            ma = mem_addr; mw = 32'(mem_we); md = mem_wdata;
          end else begin
            chk("mem_addr_stable", mem_addr, ma);
            chk("mem_we_stable", 32'(mem_we), mw);
            chk("mem_wdata_stable", mem_wdata, md);
          end
          if (mc == lat) begin
            mem_ack   = 1'b1;
            mem_rdata = memrd(wa);
          end
        end
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        n++;
      end
    end
    chk("resp_seen", 32'(done), 1);
    chk("latency", n, exp_lat);
    chk("mem_cycles", mc, exp_mem ? lat : 0);
    if (exp_mem) begin
      chk("mem_addr", ma, wa);
      chk("mem_we", mw, 32'(we));
      if (we) chk("mem_wdata", md, wd);
    end
    chk(we ? "rdata_hold" : "rdata", cpu_rdata, exp_rd);

    if (hit) begin
      m_hits++;
      if (we) m_d[s][i] = wd;
      m_touch(s, i);
    end else begin
      m_miss++;
      if (!we) m_fill(s, wa, exp_rd);
    end
    if (we) mem[wa] = wd;
    else last_rd = exp_rd;
    chk("hit_count", hit_count, m_hits);
    chk("miss_count", miss_count, m_miss);
    @(negedge clk);
    chk("resp_one_cycle", 32'(cpu_resp_valid), 0);
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    m_clear();
    chk("flush_hits_kept", hit_count, m_hits);
    chk("flush_miss_kept", miss_count, m_miss);
  endtask

  initial begin
    int n;
    logic [31:0] a;
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; flush = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    m_clear(); m_hits = 0; m_miss = 0; last_rd = '0;
    mem[32'h40] = 32'hDEAD_BEEF;
    #1;
    chk("rst_ready", 32'(cpu_ready), 1);
    chk("rst_resp", 32'(cpu_resp_valid), 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_hits", hit_count, 0);
    chk("rst_miss", miss_count, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    req(0, 32'h40, 0, 3);
    chk("tp_first_rdata", cpu_rdata, 32'hDEAD_BEEF);
    chk("tp_first_miss", miss_count, 1);
    req(0, 32'h40, 0, 1);
    chk("tp_rehit_rdata", cpu_rdata, 32'hDEAD_BEEF);
    chk("tp_rehit_hits", hit_count, 1);

    req(0, 32'h000, 0, 1);
    req(0, 32'h080, 0, 2);
    req(0, 32'h0C0, 0, 1);
    req(0, 32'h000, 0, 1);
    req(0, 32'h100, 0, 1);
    req(0, 32'h040, 0, 2);
    req(0, 32'h000, 0, 1);
    req(0, 32'h100, 0, 1);
    chk("tp_lru_hits", hit_count, 4);
    chk("tp_lru_miss", miss_count, 6);

    req(1, 32'h040, 32'h1234_5678, 2);
    req(0, 32'h040, 0, 1);
    chk("tp_store_rdata", cpu_rdata, 32'h1234_5678);
    req(1, 32'h200, 32'hCAFE_0200, 1);
    req(0, 32'h200, 0, 1);

    do_flush();
    req(0, 32'h000, 0, 1);
    req(0, 32'h100, 0, 2);
    req(0, 32'h040, 0, 1);

    for (int k = 0; k < 200; k++) begin
      a = (32'($urandom_range(0, 5)) << 6) | (32'($urandom_range(0, 1)) << 2)
        | 32'($urandom_range(0, 3));
      if (k % 37 == 36) do_flush();
      req($urandom_range(0, 3) == 0, a, $urandom, $urandom_range(1, 4));
    end

    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h3000;
    @(negedge clk);
    cpu_req = 1'b0;
    n = 0;
    while (!mem_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_req_up", 32'(mem_req), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req_drop", 32'(mem_req), 0);
    chk("rst_mid_ready", 32'(cpu_ready), 1);
    chk("rst_mid_resp", 32'(cpu_resp_valid), 0);
    chk("rst_mid_hits", hit_count, 0);
    chk("rst_mid_miss", miss_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_clear(); m_hits = 0; m_miss = 0; last_rd = '0;
    req(0, 32'h40, 0, 1);
    req(0, 32'h3000, 0, 2);
    req(0, 32'h40, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/set_assoc_cache.md
Name: set_assoc_cache

Overview:
- Parametrised N-way set-associative, write-through, no-write-allocate data cache with true-LRU replacement.
- Sits between the CPU load/store path and data memory, and talks to memory through a req/ack handshake so it tolerates variable memory latency.
- Blocking: one outstanding CPU request at a time.
- Also provides a single-cycle flush and hit/miss event counters.

Parameters:
- WIDTH, 32: data and address width in bits.
- SET_BITS, 4: log2 of the number of sets.
- WAYS, 4: associativity; a power of two, at least 2.
- TAG_BITS, WIDTH-SET_BITS-2: derived tag width; lines are one word, and address bits [1:0] are ignored.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- cpu_req_i  in  1  request valid; accepted when cpu_req_i and cpu_ready_o are both high.
- cpu_we_i  in  1  1 = store, 0 = load.
- cpu_addr_i  in  WIDTH  byte address; tag = [WIDTH-1:SET_BITS+2], set = [SET_BITS+1:2].
- cpu_wdata_i  in  WIDTH  store data.
- cpu_ready_o  out  1  high only in IDLE.
- cpu_resp_valid_o  out  1  one-cycle pulse marking completion of the accepted request.
- cpu_rdata_o  out  WIDTH  load data; valid while cpu_resp_valid_o is high and held until the next load completes.
- flush_i  in  1  invalidate all lines; honoured only in IDLE with cpu_req_i low.
- mem_req_o  out  1  memory request; held high until mem_ack_i.
- mem_we_o  out  1  memory write.
- mem_addr_o  out  WIDTH  word-aligned address (bits [1:0] = 0).
- mem_wdata_o  out  WIDTH  memory write data.
- mem_rdata_i  in  WIDTH  memory read data; sampled in the mem_ack_i cycle.
- mem_ack_i  in  1  memory completion; ignored unless mem_req_o is high.
- hit_count_o  out  32  number of lookup hits; wraps.
- miss_count_o  out  32  number of lookup misses; wraps.

Behaviour:
- Reset (asynchronous assert):
  - state = IDLE; all valid bits cleared.
  - LRU age of way w in every set = w.
  - All outputs 0 except cpu_ready_o = 1.
  - Counters cleared. Tag/data arrays are not reset.
- Reset mid-operation aborts: mem_req_o drops immediately and no fill or LRU update occurs.
- State machine: IDLE, LOOKUP, MEM_RD, MEM_WR.
- IDLE:
  - On accept, register we/addr/wdata and go to LOOKUP.
  - Else if flush_i is high, clear all valid bits in one cycle. LRU ages and counters are unchanged.
- LOOKUP: compare the registered tag against all valid ways of the set. At most one way may match.
  - Read hit: cpu_rdata_o <= matching data; cpu_resp_valid_o pulses the next cycle; hit_count++; LRU touch of the hit way; go to IDLE. Latency from the accept edge to the response cycle is 2 cycles.
  - Read miss: miss_count++; go to MEM_RD.
  - Write hit: update data in the hit way; LRU touch; hit_count++; go to MEM_WR.
  - Write miss: miss_count++; no allocation; go to MEM_WR.
- MEM_RD: mem_req_o = 1, mem_we_o = 0, mem_addr_o = registered address. On mem_ack_i:
  - Fill the victim way: data = mem_rdata_i, tag set, valid = 1.
  - LRU touch of the victim.
  - cpu_rdata_o <= mem_rdata_i, cpu_resp_valid_o pulses the next cycle, go to IDLE.
- MEM_WR: mem_req_o = 1, mem_we_o = 1, mem_wdata_o = registered wdata. On mem_ack_i, cpu_resp_valid_o pulses the next cycle; go to IDLE. cpu_rdata_o is unchanged.
- mem_ack_i may arrive in the first cycle mem_req_o is high. The minimum miss latency is then 3 cycles from accept to response.
- Memory outputs stay stable while mem_req_o is high.
- Victim selection: the lowest-index invalid way; if all ways are valid, the way with age WAYS-1.
- LRU touch of way k: every way in the set with age < age[k] increments, then age[k] = 0. The ages in a set always form a permutation of 0..WAYS-1.
- cpu_resp_valid_o and cpu_ready_o are both high in the cycle after completion, so a new request may be accepted in the response cycle.
- Inputs arriving while cpu_ready_o is low are ignored.

Test Plan:
- Reset, then load 0x0000_0040 with mem_ack_i after 3 cycles and mem_rdata_i = 0xDEAD_BEEF:
  - mem_req_o is high for 3 cycles with mem_addr_o = 0x40.
  - cpu_rdata_o = 0xDEAD_BEEF; miss_count_o = 1.
  - A repeat load of 0x40 responds 2 cycles after accept with 0xDEAD_BEEF, mem_req_o stays low, and hit_count_o = 1.
- Fill set 0 (WAYS=4) with addresses 0x000, 0x040, 0x080, 0x0C0, touch 0x000, then load 0x100:
  - The victim is the way holding 0x040.
  - A later load of 0x040 misses; loads of 0x000 and 0x100 hit.
- Store 0x1234_5678 to cached address 0x040:
  - mem_we_o = 1, mem_wdata_o = 0x1234_5678.
  - A subsequent load of 0x040 hits and returns 0x1234_5678.
- Store to uncached address 0x200:
  - A memory write is issued.
  - A following load of 0x200 misses (no allocation).
- After several fills, assert flush_i for one cycle in IDLE: every subsequent load misses, and the counters keep their values.
- Deassert rst_ni while in MEM_RD with mem_req_o high:
  - mem_req_o drops immediately and cpu_ready_o = 1.
  - All lines are invalid.
